// File: rtl/functions.sv
// Shared CLIC types: default widths, register field selects, attr layout and
// the pending vector type consumed by the priority encoder.
package functions;

  localparam int CLIC_NUM_INT = 4;
  localparam int CLIC_LVL_W   = 8;

  // Low two address bits select one of these per-interrupt fields.
  typedef enum logic [1:0] {
    FLD_IP   = 2'd0,
    FLD_IE   = 2'd1,
    FLD_ATTR = 2'd2,
    FLD_CTL  = 2'd3
  } fld_e;

  // pol sits in bit1, trig in bit0 of the attr field.
  typedef struct packed {
    logic pol;   // 0 active-high, 1 active-low
    logic trig;  // 0 level, 1 edge
  } attr_t;

  // Encoder input vector for the default configuration.
  typedef logic [CLIC_NUM_INT-1:0][CLIC_LVL_W-1:0] pend_vec_t;

endpackage

// File: rtl/clic_edge_det.sv
// Per-line front end: optional 2-flop synchronizer, polarity, act_q, edge pulse.
// Macro CLIC_SYNC_EN enables the synchronizer (adds 2 cycles of latency).
module clic_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_irq,
  input  logic i_pol,
  output logic o_act,
  output logic o_edge
);

  logic w_irq_s;
  logic r_act_q;

`ifdef CLIC_SYNC_EN
  logic [1:0] r_sync;

  // Two-stage synchronizer; the line is only observed through r_sync[1].
  always_ff @(posedge clk) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[0], i_irq};
  end

  assign w_irq_s = r_sync[1];
`else
  assign w_irq_s = i_irq;
`endif

  // A polarity flip changes act immediately, so it can produce an edge.
  assign o_act = w_irq_s ^ i_pol;

  // Previous act; reset to 0 so an already-active line edges after release.
  always_ff @(posedge clk) begin
    if (!rst_n) r_act_q <= 1'b0;
    else        r_act_q <= o_act;
  end

  assign o_edge = o_act & ~r_act_q;

endmodule

// File: rtl/clic_pending_gate.sv
// CLIC pending/enable/level gate feeding the priority encoder.
// Macro CLIC_SYNC_EN adds a 2-flop synchronizer on each irq line.
// LVL_W must be at least 2 (attr field is 2 bits wide).
module clic_pending_gate
  import functions::*;
#(
  parameter int NUM_INT = CLIC_NUM_INT,
  parameter int LVL_W   = CLIC_LVL_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_INT-1:0]                irq_i,
  input  logic                              reg_we,
  input  logic                              reg_re,
  input  logic [$clog2(NUM_INT)+1:0]        reg_addr,
  input  logic [LVL_W-1:0]                  reg_wdata,
  output logic [LVL_W-1:0]                  reg_rdata,
  input  logic                              claim_valid,
  input  logic [$clog2(NUM_INT)-1:0]        claim_id,
  output logic [NUM_INT-1:0][LVL_W-1:0]     pend_vec
);

  localparam int IW = $clog2(NUM_INT);

  logic [IW-1:0]                  w_idx;
  fld_e                           w_fld;
  logic                           w_idx_ok;
  logic                           w_clm_ok;
  logic [NUM_INT-1:0]             w_act;
  logic [NUM_INT-1:0]             w_edge;
  logic [NUM_INT-1:0]             w_wsel;
  logic [NUM_INT-1:0]             w_clm;
  logic [LVL_W-1:0]               w_rd_val;

  logic [NUM_INT-1:0]             r_ip;
  logic [NUM_INT-1:0]             r_ie;
  attr_t [NUM_INT-1:0]            r_attr;
  logic [NUM_INT-1:0][LVL_W-1:0]  r_ctl;
  logic [NUM_INT-1:0][LVL_W-1:0]  r_pend;
  logic [LVL_W-1:0]               r_rdata;

  assign w_idx    = reg_addr[IW+1:2];
  assign w_fld    = fld_e'(reg_addr[1:0]);
  // Out-of-range indices (non power-of-two NUM_INT) hit nothing.
  assign w_idx_ok = ({1'b0, w_idx} < (IW+1)'(NUM_INT));
  assign w_clm_ok = ({1'b0, claim_id} < (IW+1)'(NUM_INT));

  generate
    for (genvar g = 0; g < NUM_INT; g++) begin : g_line
      clic_edge_det u_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_irq  (irq_i[g]),
        .i_pol  (r_attr[g].pol),
        .o_act  (w_act[g]),
        .o_edge (w_edge[g])
      );
    end
  endgenerate

  // One-hot per-interrupt write and claim selects.
  always_comb begin
    w_wsel = '0;
    w_clm  = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      w_wsel[i] = reg_we && w_idx_ok && (w_idx == IW'(i));
      w_clm[i]  = claim_valid && w_clm_ok && (claim_id == IW'(i));
    end
  end

  // ip/ie/attr/ctl state; edge set beats claim clear beats software write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ip   <= '0;
      r_ie   <= '0;
      r_attr <= '0;
      r_ctl  <= '0;
    end else begin
      for (int i = 0; i < NUM_INT; i++) begin
        if (!r_attr[i].trig)                 r_ip[i] <= w_act[i];
        else if (w_edge[i])                  r_ip[i] <= 1'b1;
        else if (w_clm[i])                   r_ip[i] <= 1'b0;
        else if (w_wsel[i] && w_fld == FLD_IP) r_ip[i] <= reg_wdata[0];
        if (w_wsel[i]) begin
          case (w_fld)
            FLD_IE:   r_ie[i]   <= reg_wdata[0];
            FLD_ATTR: r_attr[i] <= attr_t'(reg_wdata[1:0]);
            FLD_CTL:  r_ctl[i]  <= reg_wdata;
            default:  ;
          endcase
        end
      end
    end
  end

  // Effective level per interrupt, from pre-edge register values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NUM_INT; i++)
        r_pend[i] <= (r_ip[i] & r_ie[i]) ? r_ctl[i] : '0;
    end
  end

  // Read mux; unused upper bits read as zero.
  always_comb begin
    w_rd_val = '0;
    if (w_idx_ok) begin
      case (w_fld)
        FLD_IP:   w_rd_val[0]   = r_ip[w_idx];
        FLD_IE:   w_rd_val[0]   = r_ie[w_idx];
        FLD_ATTR: w_rd_val[1:0] = r_attr[w_idx];
        FLD_CTL:  w_rd_val      = r_ctl[w_idx];
        default:  w_rd_val      = '0;
      endcase
    end
  end

  // Read data register; holds between reads, sees pre-write value.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_rdata <= '0;
    else if (reg_re) r_rdata <= w_rd_val;
  end

  assign reg_rdata = r_rdata;
  assign pend_vec  = r_pend;

endmodule
